seal_verifier: RTL

Read-side counterpart of the seal register. Firmware writes back a 3-word sealed record and the sensor_id it was committed with. The block recomputes CRC16 over the same 9-byte sequence on the shared CRC16 engine. It then checks CRC match, strict mono_count ordering and session_id consistency, and keeps pass/fail statistics.

---
 rtl/seal_verifier_if.sv | 25 ++
 rtl/seal_verifier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seal_verifier_if.sv
// Register-bus and shared-CRC-engine signals of the seal verifier.
// The slave view belongs to the verifier; the master view belongs to firmware and the engine.
interface seal_verifier_if;
  logic [7:0]  crc_byte;
  logic        crc_feed;
  logic        crc_busy;
  logic [15:0] crc_value;
  logic        crc_init;
  logic        data_wr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ctrl_wr;
  logic [9:0]  ctrl_in;
  logic [31:0] ctrl_out;

  modport slave (
    input  crc_busy, crc_value, data_wr, data_in, ctrl_wr, ctrl_in,
    output crc_byte, crc_feed, crc_init, data_out, ctrl_out
  );

  modport master (
    output crc_busy, crc_value, data_wr, data_in, ctrl_wr, ctrl_in,
    input  crc_byte, crc_feed, crc_init, data_out, ctrl_out
  );
endinterface

// File: rtl/seal_verifier.sv
// Re-derives the CRC16 of a written-back sealed record on the shared engine and checks
// CRC, monotonic counter and session id, keeping saturating accept/reject statistics.
//   state   | meaning
//   S_IDLE  | register access, waiting for start/clr
//   S_INIT  | crc_init pulse to the engine
//   S_FEED  | streaming the 9 record bytes (send / settle per byte)
//   S_CHECK | wait for engine idle, evaluate and record the result
module seal_verifier (
  input  logic clk,
  input  logic rst_n,
  seal_verifier_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_FEED  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;

  logic [31:0] r_w0, r_w1, r_w2;
  logic [1:0]  r_wr_cnt;
  logic [7:0]  r_sid;
  logic [3:0]  r_idx;
  logic        r_sent;
  logic [7:0]  r_crc_byte;
  logic        r_crc_feed, r_crc_init;
  logic [31:0] r_last_mono;
  logic        r_locked;
  logic [7:0]  r_locked_sid, r_acc_cnt, r_rej_cnt;
  logic        r_done, r_pass, r_crc_err, r_mono_err, r_sid_err, r_fmt_err;

  logic        w_clr, w_start, w_start_ok, w_feed_fire, w_adv, w_eval, w_data_we;
  logic [7:0]  w_byte, w_rec_sid;
  logic [31:0] w_rec_mono;
  logic [15:0] w_rec_crc;
  logic        w_fmt_ok, w_crc_err, w_mono_err, w_sid_err, w_pass, w_busy;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_rec_sid  = r_w1[31:24];
  assign w_rec_mono = {r_w2[31:24], r_w1[23:0]};
  assign w_rec_crc  = r_w2[23:8];
  assign w_fmt_ok   = (r_wr_cnt == 2'd3) && (r_w2[7:0] == 8'h00);
  assign w_crc_err  = (bus.crc_value != w_rec_crc);
  assign w_mono_err = r_locked && (w_rec_mono <= r_last_mono);
  assign w_sid_err  = r_locked && (w_rec_sid != r_locked_sid);
  assign w_pass     = !(w_crc_err || w_mono_err || w_sid_err);
  assign w_busy     = (r_state != S_IDLE);
  // A control write in the same cycle takes precedence over a data write.
  assign w_data_we  = (r_state == S_IDLE) && bus.data_wr && !bus.ctrl_wr;

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = r_sid;
      4'd1:    w_byte = r_w0[7:0];
      4'd2:    w_byte = r_w0[15:8];
      4'd3:    w_byte = r_w0[23:16];
      4'd4:    w_byte = r_w0[31:24];
      4'd5:    w_byte = w_rec_mono[7:0];
      4'd6:    w_byte = w_rec_mono[15:8];
      4'd7:    w_byte = w_rec_mono[23:16];
      4'd8:    w_byte = w_rec_mono[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_start     = 1'b0;
    w_start_ok  = 1'b0;
    w_feed_fire = 1'b0;
    w_adv       = 1'b0;
    w_eval      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ctrl_wr) begin
          if (bus.ctrl_in[0]) begin
            w_clr = 1'b1;
          end else if (bus.ctrl_in[1]) begin
            w_start = 1'b1;
            if (w_fmt_ok) begin
              w_start_ok  = 1'b1;
              w_state_nxt = S_INIT;
            end
          end
        end
      end
      S_INIT: w_state_nxt = S_FEED;
      S_FEED: begin
        if (!r_sent) begin
          w_feed_fire = !bus.crc_busy;
        end else if (r_crc_feed || !bus.crc_busy) begin
          // The engine only reports busy from the cycle after it sees the feed strobe.
          w_adv = 1'b1;
          if (r_idx == 4'd8) w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!bus.crc_busy) begin
          w_eval      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w0         <= 32'h0;
      r_w1         <= 32'h0;
      r_w2         <= 32'h0;
      r_wr_cnt     <= 2'd0;
      r_sid        <= 8'h00;
      r_idx        <= 4'd0;
      r_sent       <= 1'b0;
      r_crc_byte   <= 8'h00;
      r_crc_feed   <= 1'b0;
      r_crc_init   <= 1'b0;
      r_last_mono  <= 32'h0;
      r_locked     <= 1'b0;
      r_locked_sid <= 8'h00;
      r_acc_cnt    <= 8'h00;
      r_rej_cnt    <= 8'h00;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_crc_err    <= 1'b0;
      r_mono_err   <= 1'b0;
      r_sid_err    <= 1'b0;
      r_fmt_err    <= 1'b0;
    end else begin
      r_crc_init <= w_start_ok;
      r_crc_feed <= w_feed_fire;
      if (w_feed_fire) begin
        r_crc_byte <= w_byte;
        r_sent     <= 1'b1;
      end
      if (w_adv) begin
        r_sent <= 1'b0;
        r_idx  <= r_idx + 4'd1;
      end
      if (w_start_ok) begin
        r_idx  <= 4'd0;
        r_sent <= 1'b0;
      end
      if (w_data_we) begin
        case (r_wr_cnt)
          2'd1:    r_w1 <= bus.data_in;
          2'd2:    r_w2 <= bus.data_in;
          default: r_w0 <= bus.data_in;
        endcase
        r_wr_cnt <= (r_wr_cnt == 2'd3) ? 2'd1 : r_wr_cnt + 2'd1;
      end
      if (w_clr) begin
        r_last_mono  <= 32'h0;
        r_locked     <= 1'b0;
        r_locked_sid <= 8'h00;
        r_acc_cnt    <= 8'h00;
        r_rej_cnt    <= 8'h00;
        r_wr_cnt     <= 2'd0;
        r_done       <= 1'b0;
        r_pass       <= 1'b0;
        r_crc_err    <= 1'b0;
        r_mono_err   <= 1'b0;
        r_sid_err    <= 1'b0;
        r_fmt_err    <= 1'b0;
      end
      if (w_start) begin
        r_sid      <= bus.ctrl_in[9:2];
        r_wr_cnt   <= 2'd0;
        r_done     <= 1'b0;
        r_pass     <= 1'b0;
        r_crc_err  <= 1'b0;
        r_mono_err <= 1'b0;
        r_sid_err  <= 1'b0;
        r_fmt_err  <= 1'b0;
        if (!w_fmt_ok) begin
          r_fmt_err <= 1'b1;
          r_done    <= 1'b1;
          r_rej_cnt <= sat_inc(r_rej_cnt);
        end
      end
      if (w_eval) begin
        r_done     <= 1'b1;
        r_pass     <= w_pass;
        r_crc_err  <= w_crc_err;
        r_mono_err <= w_mono_err;
        r_sid_err  <= w_sid_err;
        if (w_pass) begin
          r_last_mono <= w_rec_mono;
          r_acc_cnt   <= sat_inc(r_acc_cnt);
          if (!r_locked) begin
            r_locked     <= 1'b1;
            r_locked_sid <= w_rec_sid;
          end
        end else begin
          r_rej_cnt <= sat_inc(r_rej_cnt);
        end
      end
    end
  end

  assign bus.crc_byte = r_crc_byte;
  assign bus.crc_feed = r_crc_feed;
  assign bus.crc_init = r_crc_init;
  assign bus.data_out = r_last_mono;
  assign bus.ctrl_out = {r_locked_sid, r_rej_cnt, r_acc_cnt, r_locked, r_fmt_err,
                         r_sid_err, r_mono_err, r_crc_err, r_pass, r_done, w_busy};
endmodule
